seq_det_prog: RTL and testbench

Programmable serial sequence detector, the parametrised successor to the fixed-pattern Mealy detectors in the serial-input path.
- Matches a runtime-loaded pattern of 1..MAX_LEN bits on a qualified bit stream.
- Selectable overlapping or non-overlapping detection.
- Mealy match output: asserts in the same cycle as the final bit.
- Saturating match counter with software clear.

---
 rtl/seq_det_prog.sv | 102 ++++++++++
 tb/tb_seq_det_prog.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector: runtime-loaded 1..MAX_LEN bit pattern,
// overlapping or non-overlapping Mealy match, saturating match counter.
module seq_det_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    output logic               armed,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               match,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    // Handshake: in_bit is consumed only in a cycle where in_valid=1, the
    // detector is ARMED and cfg_load=0; there is no backpressure.

    typedef enum logic {
        UNCFG = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   fill_q;
    logic               ovl_q;

    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] cand;
    logic               len_ok;
    logic               fill_ok;

    always_comb begin
        len_ok  = (cfg_len != '0) && (cfg_len <= LEN_MAX);
        mask    = ~({MAX_LEN{1'b1}} << len_q);
        cand    = {hist_q[MAX_LEN-2:0], in_bit};
        // len_q >= 1 whenever ARMED, so the subtraction cannot wrap where it matters
        fill_ok = (fill_q >= (len_q - LEN_W'(1)));
        match   = (state == ARMED) && in_valid && !cfg_load && fill_ok
                  && ((cand & mask) == (pat_q & mask));
    end

    assign armed   = (state == ARMED);
    assign cnt_sat = (match_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= UNCFG;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (cfg_load) begin
                if (len_ok) begin
                    pat_q  <= cfg_pattern;
                    len_q  <= cfg_len;
                    ovl_q  <= cfg_overlap;
                    hist_q <= '0;
                    fill_q <= '0;
                    state  <= ARMED;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else if ((state == ARMED) && in_valid) begin
                hist_q <= cand;
                // Non-overlapping: the next match must be built from fresh bits
                if (match && !ovl_q) begin
                    fill_q <= '0;
                end else if (fill_q != LEN_MAX) begin
                    fill_q <= fill_q + LEN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            match_cnt <= '0;
        end else if (match && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: queue-based reference model checked every cycle on two
// instances (8-bit and 2-bit counters) plus directed literal expectations.
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    // clock / reset
    logic clk;
    logic rst;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in_bit;
    logic               clr_cnt;

    logic       cfg_err_a, armed_a, match_a, sat_a;
    logic [7:0] cnt_a;
    logic       cfg_err_b, armed_b, match_b, sat_b;
    logic [1:0] cnt_b;

    seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err_a),
        .armed(armed_a), .in_valid(in_valid), .in_bit(in_bit), .match(match_a),
        .clr_cnt(clr_cnt), .match_cnt(cnt_a), .cnt_sat(sat_a)
    );

    seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err_b),
        .armed(armed_b), .in_valid(in_valid), .in_bit(in_bit), .match(match_b),
        .clr_cnt(clr_cnt), .match_cnt(cnt_b), .cnt_sat(sat_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // reference model: received bits since the last reset/load/non-overlap match
    logic       bit_q[$];
    logic       m_live = 1'b0;
    logic       m_armed, m_ovl, m_err;
    logic [7:0] m_pat;
    int         m_len, m_cnt8, m_cnt2;
    logic       m_exp_match;

    function automatic logic model_match();
        int n;
        if (!m_armed || !in_valid || cfg_load) return 1'b0;
        n = bit_q.size();
        if (n + 1 < m_len) return 1'b0;
        if (in_bit != m_pat[0]) return 1'b0;
        for (int j = 1; j < m_len; j++)
            if (bit_q[n-j] != m_pat[j]) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (m_live) begin
            m_exp_match = model_match();
            check("match_a", 32'(match_a), 32'(m_exp_match));
            check("match_b", 32'(match_b), 32'(m_exp_match));
            check("armed_a", 32'(armed_a), 32'(m_armed));
            check("armed_b", 32'(armed_b), 32'(m_armed));
            check("cfg_err_a", 32'(cfg_err_a), 32'(m_err));
            check("cnt_a", 32'(cnt_a), 32'(m_cnt8));
            check("cnt_b", 32'(cnt_b), 32'(m_cnt2));
            check("sat_a", 32'(sat_a), 32'(m_cnt8 == 255));
            check("sat_b", 32'(sat_b), 32'(m_cnt2 == 3));
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1'b1; m_armed = 1'b0; m_ovl = 1'b0; m_err = 1'b0;
            m_pat = '0; m_len = 0; m_cnt8 = 0; m_cnt2 = 0; m_exp_match = 1'b0;
            bit_q.delete();
        end else if (m_live) begin
            m_err = 1'b0;
            if (cfg_load) begin
                if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
                    m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
                    m_armed = 1'b1;
                    bit_q.delete();
                end else begin
                    m_err = 1'b1;
                end
            end else if (m_armed && in_valid) begin
                bit_q.push_back(in_bit);
                if (m_exp_match && !m_ovl) bit_q.delete();
                else if (bit_q.size() > MAX_LEN) void'(bit_q.pop_front());
            end
            if (clr_cnt) begin
                m_cnt8 = 0; m_cnt2 = 0;
            end else if (m_exp_match) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
        rst = 1'b0; cfg_load = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic idle();
        next_cycle();
        #1;
    endtask

    task automatic reset_dut();
        next_cycle();
        rst = 1'b1;
        #1;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] len, input logic ovl);
        next_cycle();
        cfg_load = 1'b1; cfg_pattern = p; cfg_len = len; cfg_overlap = ovl;
        #1;
    endtask

    task automatic send(input logic b, input logic exp);
        next_cycle();
        in_valid = 1'b1; in_bit = b;
        #1;
        check("lit_match", 32'(match_a), 32'(exp));
    endtask

    // bits[n-1] is sent first
    task automatic stream(input logic [7:0] bits, input logic [7:0] exp, input int n);
        for (int i = n - 1; i >= 0; i--) send(bits[i], exp[i]);
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;

        // reset state
        reset_dut();
        idle();
        check("rst_armed", 32'(armed_a), 32'd0);
        check("rst_cnt", 32'(cnt_a), 32'd0);
        check("rst_err", 32'(cfg_err_a), 32'd0);
        check("rst_sat", 32'(sat_a), 32'd0);
        send(1'b1, 1'b0);

        // overlapping 1001
        load(8'b1001, 4'd4, 1'b1);
        idle();
        check("load_armed", 32'(armed_a), 32'd1);
        stream(8'b1001001, 8'b0001001, 7);
        idle();
        check("ovl_cnt", 32'(cnt_a), 32'd2);

        // non-overlapping 1001
        load(8'b1001, 4'd4, 1'b0);
        stream(8'b1001001, 8'b0001000, 7);
        idle();
        check("novl_cnt", 32'(cnt_a), 32'd3);

        // gaps are transparent, illegal loads rejected
        load(8'b1001, 4'd4, 1'b1);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        idle(); idle(); idle();
        send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        load(8'h00, 4'd0, 1'b0);
        idle();
        check("err_len0", 32'(cfg_err_a), 32'd1);
        check("err_armed", 32'(armed_a), 32'd1);
        idle();
        check("err_pulse", 32'(cfg_err_a), 32'd0);
        stream(8'b1001, 8'b0001, 4);
        load(8'hff, 4'd9, 1'b1);
        idle();
        check("err_len9", 32'(cfg_err_a), 32'd1);

        // len=1, counter saturation and clear priority
        next_cycle();
        clr_cnt = 1'b1;
        #1;
        idle();
        check("clr_cnt", 32'(cnt_a), 32'd0);
        load(8'b1, 4'd1, 1'b1);
        stream(8'b11111, 8'b11111, 5);
        send(1'b0, 1'b0);
        idle();
        check("sat_cnt_b", 32'(cnt_b), 32'd3);
        check("sat_flag_b", 32'(sat_b), 32'd1);
        check("cnt_a_5", 32'(cnt_a), 32'd5);
        next_cycle();
        in_valid = 1'b1; in_bit = 1'b1; clr_cnt = 1'b1;
        #1;
        check("clr_match", 32'(match_a), 32'd1);
        idle();
        check("clr_wins_a", 32'(cnt_a), 32'd0);
        check("clr_wins_b", 32'(cnt_b), 32'd0);

        // reset mid-stream
        load(8'b1001, 4'd4, 1'b1);
        stream(8'b100, 8'b000, 3);
        reset_dut();
        stream(8'b1001, 8'b0000, 4);
        check("post_rst_armed", 32'(armed_a), 32'd0);
        load(8'b1001, 4'd4, 1'b1);
        stream(8'b1001, 8'b0001, 4);

        // mid-stream reload with a bit on the load cycle
        stream(8'b10, 8'b00, 2);
        next_cycle();
        cfg_load = 1'b1; cfg_pattern = 8'b101; cfg_len = 4'd3; cfg_overlap = 1'b1;
        in_valid = 1'b1; in_bit = 1'b1;
        #1;
        check("load_cycle_match", 32'(match_a), 32'd0);
        stream(8'b101, 8'b001, 3);

        // full-length pattern, non-overlapping
        load(8'b10110011, 4'd8, 1'b0);
        stream(8'b10110011, 8'b00000001, 8);
        stream(8'b10110011, 8'b00000001, 8);

        idle(); idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
